// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 host transmitter types, defaults and command codes
//
// Contents:
//   ps2_tx_state_t        host-to-device transmitter FSM states
//   PS2_INHIBIT_CYCLES    default clock-inhibit length (100 us at 6.5 MHz)
//   PS2_TIMEOUT_CYCLES    default release-to-ACK limit (15 ms at 6.5 MHz)
//   PS2_FILTER_LEN        default clock glitch-filter length
//   PS2_CMD_* / PS2_ACK   keyboard command and response bytes
//   ps2_odd_parity()      parity bit that makes the 9-bit data+parity word odd

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_t;

    localparam int PS2_INHIBIT_CYCLES = 650;
    localparam int PS2_TIMEOUT_CYCLES = 97500;
    localparam int PS2_FILTER_LEN     = 4;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronizer, glitch filter and falling-edge detector
//
// Ports:
//   clk      in  keyboard-domain clock
//   reset    in  synchronous, active-high
//   i_raw    in  raw asynchronous pin level
//   o_filt   out filtered level (idles high)
//   o_fall   out one-cycle pulse on a filtered 1->0 transition, aligned with o_filt falling

module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt,
    output logic o_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_filt;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // r_cnt counts consecutive synchronized samples that disagree with the
    // filtered level; the level flips on the FILTER_LEN-th such sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_filt <= 1'b1;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_fall <= 1'b0;
            if (r_s2 != r_filt) begin
                if (r_cnt == CNT_LAST) begin
                    r_filt <= r_s2;
                    r_fall <= ~r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;
    assign o_fall = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (keyboard port)
//
// Ports:
//   clk, reset      keyboard-domain clock, synchronous active-high reset
//   tx_data/valid   command byte and request; accepted when tx_valid & tx_ready
//   tx_ready        high only in IDLE
//   tx_done         one-cycle pulse after ACK with both lines back idle
//   tx_error        one-cycle pulse on missing ACK or timeout
//   busy            high whenever not IDLE (receiver discards frames)
//   ps2_clk_i/data_i raw asynchronous pin levels
//   ps2_clk_oe/data_oe 1 pulls the open-drain line low, 0 releases it

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
    parameter int FILTER_LEN     = PS2_FILTER_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX_VAL = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW          = $clog2(CNT_MAX_VAL + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT_CYCLES);

    ps2_tx_state_t r_state, w_next_state;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_bitcnt, w_bitcnt_next;
    logic [9:0]    r_shreg, w_shreg_next;
    logic          r_data_oe, w_data_oe_next;
    logic          r_data_s1, r_data_s2;

    logic          w_clk_filt;
    logic          w_clk_fall;
    logic          w_tmo_state;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .i_raw  (ps2_clk_i),
        .o_filt (w_clk_filt),
        .o_fall (w_clk_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_data_s1 <= ps2_data_i;
            r_data_s2 <= r_data_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shreg   <= '0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_cnt_next;
            r_bitcnt  <= w_bitcnt_next;
            r_shreg   <= w_shreg_next;
            r_data_oe <= w_data_oe_next;
        end
    end

    // The timeout window opens at RTS; checking it ahead of the per-state
    // logic makes a timeout win over an ACK edge landing on the same cycle.
    assign w_tmo_state = (r_state == ST_RTS) || (r_state == ST_SHIFT) ||
                         (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);

    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
        w_bitcnt_next  = r_bitcnt;
        w_shreg_next   = r_shreg;
        w_data_oe_next = r_data_oe;
        tx_done        = 1'b0;
        tx_error       = 1'b0;

        if (w_tmo_state && (r_cnt >= TMO)) begin
            tx_error       = 1'b1;
            w_data_oe_next = 1'b0;
            w_next_state   = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_next     = '0;
                    w_data_oe_next = 1'b0;
                    if (tx_valid) begin
                        w_shreg_next = {1'b1, ps2_odd_parity(tx_data), tx_data};
                        w_next_state = ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (r_cnt == INH_LAST) begin
                        w_data_oe_next = 1'b1;      // start bit
                        w_cnt_next     = '0;
                        w_next_state   = ST_RTS;
                    end
                end
                ST_RTS: begin
                    w_cnt_next    = '0;
                    w_bitcnt_next = '0;
                    w_next_state  = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_clk_fall) begin
                        w_data_oe_next = ~r_shreg[0];
                        w_shreg_next   = {1'b0, r_shreg[9:1]};
                        w_bitcnt_next  = r_bitcnt + 1'b1;
                        if (r_bitcnt == 4'd9) begin
                            w_next_state = ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    if (w_clk_fall) begin
                        if (!r_data_s2) begin
                            w_next_state = ST_WAIT_IDLE;
                        end else begin
                            tx_error     = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_clk_filt && r_data_s2) begin
                        tx_done      = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_data_oe_next = 1'b0;
                    w_next_state   = ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign ps2_clk_oe  = (r_state == ST_INHIBIT) || (r_state == ST_RTS);
    assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int TMO = 3000;
    localparam int FL  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;
    logic       line_clk, line_data;

    assign line_clk  = ~ps2_clk_oe & dev_clk;
    assign line_data = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .busy        (busy),
        .ps2_clk_i   (line_clk),
        .ps2_data_i  (line_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cnt_done = 0;
    int cnt_err = 0;
    int busy_gap = 0;
    bit in_frame = 0;
    bit frame_over = 0;

    always @(negedge clk) begin
        if (in_frame && !frame_over && busy !== 1'b1) busy_gap++;
        if (tx_done === 1'b1) cnt_done++;
        if (tx_error === 1'b1) cnt_err++;
        if (tx_done === 1'b1 || tx_error === 1'b1) frame_over = 1;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: cycle budget exceeded");
        $fatal(1, "watchdog");
    end

    // Line levels a device sees on its rising edges: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_bits(input logic [7:0] d);
        logic [10:0] b;
        int ones;
        ones = 0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[i+1] = d[i];
            ones += int'(d[i]);
        end
        b[9]  = ((ones % 2) == 0);
        b[10] = 1'b1;
        return b;
    endfunction

    // Accept the byte and measure the inhibit/RTS window; returns at the first
    // cycle with the clock line released.
    task automatic send_accept(input logic [7:0] d);
        int k, first_d;
        k = 0;
        while (tx_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        check_eq("ready_before_send", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid   = 1'b0;
        frame_over = 0;
        busy_gap   = 0;
        k = 0;
        first_d = 0;
        while (ps2_clk_oe === 1'b1 && k < INH + 10) begin
            k++;
            if (ps2_data_oe === 1'b1 && first_d == 0) first_d = k;
            @(negedge clk);
        end
        check_eq("clk_oe_high_cycles", 32'(k), 32'(INH + 1));
        check_eq("data_oe_rise_cycle", 32'(first_d), 32'(INH + 1));
    endtask

    task automatic device_clock(input int half, input bit ack, input int abort_after,
                                input bit inject, output logic [10:0] bits, output int lat);
        bit stop;
        stop = 0;
        lat  = 0;
        bits = '0;
        repeat (half) @(negedge clk);
        bits[0] = line_data;
        for (int p = 1; p <= 11 && !stop; p++) begin
            if (p == 11 && ack) dev_data_low = 1'b1;
            dev_clk = 1'b0;
            for (int j = 1; j <= half; j++) begin
                if (inject && p == 3 && j == 1) begin tx_data = 8'h00; tx_valid = 1'b1; end
                @(negedge clk);
                if (inject && p == 3 && j == 1) begin
                    check_eq("busy_reject_ready", 32'(tx_ready), 32'd0);
                    tx_valid = 1'b0;
                end
                if (p == 1 && lat == 0 && ps2_data_oe === 1'b0) lat = j;
            end
            dev_clk = 1'b1;
            if (p <= 10) bits[p] = line_data;
            if (p == abort_after) stop = 1;
            else repeat (half) @(negedge clk);
        end
        dev_data_low = 1'b0;
    endtask

    task automatic finish_frame();
        int k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check_eq("frame_returns_idle", 32'(tx_ready), 32'd1);
        in_frame = 0;
        repeat (2) @(negedge clk);
    endtask

    // Full frame against the device model; compares bits and outcome with the model.
    task automatic run_frame(input string tag, input logic [7:0] d, input int half,
                             input bit ack, input bit inject, output logic [10:0] bits);
        int d0, e0, lat;
        d0 = cnt_done;
        e0 = cnt_err;
        send_accept(d);
        in_frame = 1;
        device_clock(half, ack, 0, inject, bits, lat);
        finish_frame();
        check_eq({tag, "_bits"}, 32'(bits), 32'(exp_bits(d)));
        check_eq({tag, "_done"}, 32'(cnt_done - d0), ack ? 32'd1 : 32'd0);
        check_eq({tag, "_error"}, 32'(cnt_err - e0), ack ? 32'd0 : 32'd1);
        if (ack) check_eq({tag, "_busy_gap"}, 32'(busy_gap), 32'd0);
        if (d[0]) check_eq({tag, "_fall_to_data"}, 32'(lat), 32'(2 + FL + 1));
        check_eq({tag, "_lines_released"}, {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    logic [10:0] bits;
    logic [7:0]  rd;
    int          k, d0, e0, lat;
    bit          ack;

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check_eq("reset_data_oe", 32'(ps2_data_oe), 32'd0);
        check_eq("reset_tx_done", 32'(tx_done), 32'd0);
        check_eq("reset_tx_error", 32'(tx_error), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame("leds_ed", PS2_CMD_LEDS, 14, 1'b1, 1'b0, bits);
        run_frame("enable_f4", PS2_CMD_ENABLE, 12, 1'b1, 1'b0, bits);
        check_eq("enable_f4_parity", 32'(bits[9]), 32'd0);
        run_frame("no_ack", PS2_CMD_RESET, 11, 1'b0, 1'b0, bits);

        // Timeout: device never clocks after the clock line is released.
        d0 = cnt_done;
        e0 = cnt_err;
        send_accept(8'hA5);
        k = 0;
        while (tx_error !== 1'b1 && k < TMO + 20) begin @(negedge clk); k++; end
        check_eq("timeout_cycles", 32'(k), 32'(TMO));
        @(negedge clk);
        check_eq("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check_eq("timeout_ready", 32'(tx_ready), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("timeout_err_count", 32'(cnt_err - e0), 32'd1);
        check_eq("timeout_no_done", 32'(cnt_done - d0), 32'd0);

        // Reset after the fifth device clock edge.
        send_accept(8'h3C);
        device_clock(12, 1'b1, 5, 1'b0, bits, lat);
        check_eq("mid_frame_busy", 32'(busy), 32'd1);
        d0 = cnt_done;
        e0 = cnt_err;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check_eq("mid_reset_ready", 32'(tx_ready), 32'd1);
        check_eq("mid_reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_reset_no_pulse", 32'((cnt_done - d0) + (cnt_err - e0)), 32'd0);

        // Busy rejection, then an immediate follow-up command.
        run_frame("busy_reject", PS2_CMD_RESET, 13, 1'b1, 1'b1, bits);
        rd = 8'($urandom_range(0, 255));
        run_frame("after_reject", rd, 12, 1'b1, 1'b0, bits);

        for (int n = 0; n < 6; n++) begin
            rd  = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rand%0d", n), rd, int'($urandom_range(10, 20)), ack, 1'b0, bits);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter for the keyboard port: it sends command bytes such as 0xFF (reset), 0xED (set LEDs) and 0xF4 (enable) to the keyboard. It is the opposite direction of the existing PS/2 receive path that produces the 11-bit `ps2_key` event word.
- Runs on the keyboard clock domain, the same clock as the keyboard matrix (`clkcpu`, 6.5 MHz nominal).
- Drives the shared open-drain PS/2 clock and data lines.
- Asserts `busy` so the receiver discards frames while a command is in flight.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 650: cycles the clock line is held low before request-to-send (≥100 µs at 6.5 MHz).
- `TIMEOUT_CYCLES`, default 97500: maximum cycles from releasing clock to ACK completion (15 ms).
- `FILTER_LEN`, default 4: consecutive equal samples needed to accept a level change on `ps2_clk_i`.

Ports:
- `clk` in 1: keyboard-domain clock.
- `reset` in 1: synchronous, active-high.
- `tx_data` in 8: command byte, captured when `tx_valid & tx_ready`.
- `tx_valid` in 1: request to send.
- `tx_ready` out 1: high only in IDLE.
- `tx_done` out 1: one-cycle pulse when the device ACKs and both lines are idle.
- `tx_error` out 1: one-cycle pulse on missing ACK or timeout.
- `busy` out 1: high in every state except IDLE.
- `ps2_clk_i` in 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_i` in 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls the clock line low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the data line low; 0 releases it.

## Operation
Input conditioning:
- Both inputs pass through 2-flop synchronizers.
- The clock input then goes through a `FILTER_LEN` glitch filter.
- A falling edge is a filtered 1→0 transition.

States:
- **IDLE**: both `oe` low, `tx_ready`=1.
  - On accept: latch `tx_data`, compute odd parity (`~^tx_data`), load `shreg` = {1'b1 stop, parity, data}, clear the counter, go to INHIBIT.
- **INHIBIT**: `ps2_clk_oe`=1 for `INHIBIT_CYCLES`.
  - On the last cycle, assert `ps2_data_oe`=1 (start bit 0), go to RTS.
- **RTS**: hold `ps2_data_oe`=1 for 1 cycle with `ps2_clk_oe`=1, then release `ps2_clk_oe`.
  - Start the timeout counter, set `bitcnt`=0, go to SHIFT.
- **SHIFT**: on each falling edge, drive `ps2_data_oe` = ~`shreg[0]`, shift right, increment `bitcnt`.
  - Edges 1–8 carry data LSB first, edge 9 carries parity, edge 10 carries the stop bit (release).
  - After edge 10, go to ACK.
- **ACK**: on the next falling edge (the 11th), sample synchronized `ps2_data_i`.
  - 0: go to WAIT_IDLE.
  - 1: pulse `tx_error`, go to IDLE.
- **WAIT_IDLE**: wait until filtered clock = 1 and synced data = 1, then pulse `tx_done` and go to IDLE.
- **Timeout**: in RTS, SHIFT, ACK or WAIT_IDLE, reaching `TIMEOUT_CYCLES` pulses `tx_error`, releases both lines, and returns to IDLE.
- **Reset values**: all outputs 0 except `tx_ready`=1. Reset mid-frame releases both lines on the next clock edge, with no `tx_done`/`tx_error` pulse.
- **Simultaneous events**:
  - `tx_valid` while `busy` is ignored; no queuing.
  - A timeout on the same cycle as the ACK edge resolves as the timeout (error wins).
- **Counters**: `bitcnt` is 4 bits. The cycle counter is `$clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)` bits, shared between INHIBIT and the timeout, saturating and never wrapping.

## Timing
- Accept to `ps2_clk_oe` rising: 1 cycle.
- `ps2_clk_oe` is high for exactly `INHIBIT_CYCLES`+1 cycles. `ps2_data_oe` rises on the last of these cycles.
- Pin falling edge to `ps2_data_oe` update: 2 (synchronizer) + `FILTER_LEN` + 1 cycles. This is 7 cycles at defaults, well inside the ≥5 µs low phase of the device clock.
- `tx_done`/`tx_error` assert for exactly 1 cycle. `tx_ready` returns high on the following cycle.
- Back-to-back commands: the earliest next accept is the cycle after `tx_ready` rises.

## Structure
- **Package `ps2_pkg`**: state enum, default `INHIBIT_CYCLES`/`TIMEOUT_CYCLES`, PS/2 command constants (`PS2_CMD_RESET`=8'hFF, `PS2_CMD_LEDS`=8'hED, `PS2_CMD_ENABLE`=8'hF4, `PS2_ACK`=8'hFA).
- **Sub-module `ps2_line_filter`**: 2-flop synchronizer, `FILTER_LEN` filter and falling-edge pulse. It is reusable by the receiver.
- FSM, shift register and counters stay in `ps2_host_tx`.
- Top level builds open-drain pads as `oe ? 1'b0 : 1'bz`.

## Test plan
- **Normal 0xED**: send 0xED with a device model clocking at 12 kHz. Required response:
  - sampled bits on rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1;
  - the ACK is answered by `tx_done` pulse;
  - `busy` is high throughout the frame.
- **Parity 0 case**: send 0xF4 (5 ones). Required response: parity bit sampled as 0, `tx_done` asserted.
- **Missing ACK**: the device leaves data high on the 11th edge. Required response: `tx_error` pulse, no `tx_done`, both `oe` low the next cycle.
- **Timeout**: the device never clocks after RTS. Required response: `tx_error` exactly `TIMEOUT_CYCLES` cycles after `ps2_clk_oe` falls, both lines released.
- **Reset mid-frame**: assert `reset` after edge 5. Required response: both `oe`=0 and `tx_ready`=1 on the next cycle, no pulse outputs.
- **Busy rejection**: pulse `tx_valid` with 0x00 during SHIFT of 0xFF. Required response: only 0xFF is transmitted, then the next accept succeeds after `tx_done`.
